// File: rtl/mp_add_seq.sv
// mp_add_seq: multi-precision add/subtract sequencer driving one shared W-bit adder slice per cycle, LSW first
module mp_add_seq #(
    parameter int W     = 32,
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic                 sub,
    input  logic                 cin_in,
    input  logic [WORDS*W-1:0]   op_a,
    input  logic [WORDS*W-1:0]   op_b,
    output logic                 ready,
    output logic                 done,
    output logic [WORDS*W-1:0]   sum,
    output logic                 cout,
    output logic                 ovf,
    output logic [W-1:0]         add_op1,
    output logic [W-1:0]         add_op2,
    output logic                 add_cin,
    input  logic [W-1:0]         add_result,
    input  logic                 add_cout
);
    localparam int IW  = $clog2(WORDS);
    localparam int MSB = WORDS*W-1;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    logic [1:0]         state;
    logic [IW-1:0]      idx;
    logic               carry;
    logic [WORDS*W-1:0] a_r, b_r;
    logic               last;
    assign last  = idx == IW'(WORDS-1);
    assign ready = state == IDLE;
    assign done  = state == DONE;
    always_comb begin
        add_op1 = state == RUN ? a_r[idx*W +: W] : '0;
        add_op2 = state == RUN ? b_r[idx*W +: W] : '0;
        add_cin = state == RUN ? carry : 1'b0;
    end
    // b_r holds ~op_b for subtract, so the overflow test below works for both ops
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            carry <= 1'b0;
            a_r   <= '0;
            b_r   <= '0;
        end else if (state == IDLE) begin
            if (start) begin
                a_r   <= op_a;
                b_r   <= sub ? ~op_b : op_b;
                carry <= sub ? 1'b1 : cin_in;
                idx   <= '0;
                sum   <= '0;
                state <= RUN;
            end
        end else if (state == RUN) begin
            sum[idx*W +: W] <= add_result;
            carry           <= add_cout;
            if (last) begin
                cout  <= add_cout;
                ovf   <= (a_r[MSB] == b_r[MSB]) && (add_result[W-1] != a_r[MSB]);
                state <= DONE;
            end else begin
                idx <= idx + 1'b1;
            end
        end else begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_mp_add_seq.sv
// tb_mp_add_seq: scoreboard bench for mp_add_seq against a wide-arithmetic reference model
module tb_mp_add_seq;
    localparam int W = 32, WORDS = 4, N = W*WORDS;
    logic clk = 1'b0, resetn = 1'b0, start = 1'b0, sub = 1'b0, cin_in = 1'b0;
    logic [N-1:0] op_a = '0, op_b = '0, sum;
    logic ready, done, cout, ovf, add_cin, add_cout;
    logic [W-1:0] add_op1, add_op2, add_result;
    int checks = 0, failures = 0, cyc = 0, ndone = 0;
    typedef struct {
        logic [N-1:0] sum_e;
        logic         cout_e;
        logic         ovf_e;
        int           t;
    } exp_t;
    exp_t sb[$];
    logic [N-1:0] last_sum = '0;

    mp_add_seq #(.W(W), .WORDS(WORDS)) dut (
        .clk(clk), .resetn(resetn), .start(start), .sub(sub), .cin_in(cin_in),
        .op_a(op_a), .op_b(op_b), .ready(ready), .done(done), .sum(sum),
        .cout(cout), .ovf(ovf), .add_op1(add_op1), .add_op2(add_op2),
        .add_cin(add_cin), .add_result(add_result), .add_cout(add_cout)
    );

    // the shared combinational adder
    assign {add_cout, add_result} = {1'b0, add_op1} + {1'b0, add_op2} + {{W{1'b0}}, add_cin};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [N-1:0] a, input logic [N-1:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %h want %h", n, a, e);
        end
    endtask

    task automatic chk1(input string n, input logic a, input logic e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %b want %b", n, a, e);
        end
    endtask

    task automatic chki(input string n, input int a, input int e);
        checks++;
        if (a != e) begin
            failures++;
            $display("FAIL %s: got %0d want %0d", n, a, e);
        end
    endtask

    function automatic logic [N-1:0] rnd();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // full-width integer arithmetic, independent of slicing
    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                   input logic s, input logic c, input int t);
        exp_t e;
        logic [N:0] u;
        logic signed [N+1:0] sa, sbv, sr, mx, mn;
        u  = {1'b0, a} + {1'b0, b} + (N+1)'(c);
        sa = $signed({{2{a[N-1]}}, a});
        sbv = $signed({{2{b[N-1]}}, b});
        sr = s ? sa - sbv : sa + sbv + $signed((N+2)'(c));
        mx = $signed({3'b000, {(N-1){1'b1}}});
        mn = $signed({3'b111, {(N-1){1'b0}}});
        e.sum_e  = s ? a - b : u[N-1:0];
        e.cout_e = s ? (a >= b) : u[N];
        e.ovf_e  = (sr > mx) || (sr < mn);
        e.t      = t;
        return e;
    endfunction

    always @(negedge clk) begin
        if (resetn && done) begin
            exp_t e;
            ndone++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 want no pending op");
            end else begin
                e = sb.pop_front();
                chk("sum", sum, e.sum_e);
                chk1("cout", cout, e.cout_e);
                chk1("ovf", ovf, e.ovf_e);
                chki("done_cycle", cyc, e.t);
                chk1("ready_in_done", ready, 1'b0);
                last_sum = e.sum_e;
            end
        end
    end

    task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic s, input logic c);
        int n = 0;
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk1("ready_wait", ready, 1'b1);
        chk("sum_held", sum, last_sum);
        op_a = a; op_b = b; sub = s; cin_in = c; start = 1'b1;
        sb.push_back(model(a, b, s, c, cyc + 1 + WORDS));
    endtask

    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s, input logic c);
        issue(a, b, s, c);
        @(negedge clk);
        start = 1'b0;
        op_a = rnd(); op_b = rnd(); sub = 1'($urandom()); cin_in = 1'($urandom());
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chki("drain", sb.size(), 0);
    endtask

    task automatic chk_idle_ports(input string n);
        chk1({n, "_ready"}, ready, 1'b1);
        chk1({n, "_done"}, done, 1'b0);
        chk({n, "_sum"}, sum, '0);
        chk1({n, "_cout"}, cout, 1'b0);
        chk1({n, "_ovf"}, ovf, 1'b0);
        chk({n, "_adder"}, N'({add_op1, add_op2, add_cin}), '0);
    endtask

    initial begin
        logic [N-1:0] ones, msb;
        int d0;
        ones = '1;
        msb  = {1'b1, {(N-1){1'b0}}};
        repeat (2) @(negedge clk);
        chk_idle_ports("reset");
        resetn = 1'b1;
        @(negedge clk);
        do_op({96'h0, 32'hFFFF_FFFF}, N'(1), 1'b0, 1'b0);
        drain();
        chk("carry_chain", sum, {64'h0, 32'h1, 32'h0});
        do_op(ones, '0, 1'b0, 1'b1);
        drain();
        chk("allones_plus_cin", sum, '0);
        chk1("allones_cout", cout, 1'b1);
        do_op(N'(5), N'(7), 1'b1, 1'b0);
        drain();
        chk("sub_5_7", sum, ones - N'(1));
        chk1("sub_5_7_borrow", cout, 1'b0);
        do_op(msb, N'(1), 1'b1, 1'b1);
        drain();
        chk("sub_min_1", sum, ~msb);
        chk1("sub_min_1_ovf", ovf, 1'b1);
        // start held high through RUN/DONE with inputs churning: one op only
        d0 = ndone;
        issue(rnd(), rnd(), 1'($urandom()), 1'($urandom()));
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            op_a = rnd(); op_b = rnd(); sub = 1'($urandom()); cin_in = 1'($urandom());
        end
        start = 1'b0;
        repeat (4) @(negedge clk);
        chki("single_accept", ndone - d0, 1);
        chki("single_accept_queue", sb.size(), 0);
        // abort mid-RUN
        do_op(rnd(), rnd(), 1'b0, 1'b1);
        @(negedge clk);
        resetn = 1'b0;
        sb.delete();
        last_sum = '0;
        @(negedge clk);
        chk_idle_ports("abort");
        resetn = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 1000; i++) begin
            logic [N-1:0] a, b;
            a = rnd();
            b = ($urandom_range(0, 15) == 0) ? a : rnd();
            if ($urandom_range(0, 15) == 0) a = ($urandom_range(0, 1) == 0) ? ones : msb;
            do_op(a, b, 1'($urandom()), 1'($urandom()));
        end
        drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
